// File: rtl/usart_core_if.sv
// Bus-side register port of the USART: address, strobes and data.
// The bus master drives requests; the core returns registered read data.
interface usart_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr, wr_en, rd_en, wdata,
    input  rdata
  );

  modport slave (
    input  addr, wr_en, rd_en, wdata,
    output rdata
  );
endinterface

// File: rtl/usart_core.sv
// Byte-wide USART: register file, 8N1 transmitter and receiver.
// Async mode runs off a baud divider, sync mode off the external xcki.
module usart_core #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  usart_core_if.slave bus,
  input  logic        xcki,
  input  logic        rxd,
  output logic        txd
);

  localparam int TC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_W);

  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);
  localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

  localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_BAUD = ADDR_W'(3);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [2:0]        ctrl_q;
  logic [DATA_W-1:0] baud_q;
  logic [DATA_W-1:0] brg_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] tx_buf_q;
  logic [DATA_W-1:0] rx_buf_q;
  logic              txe_q;
  logic              rxc_q;
  logic              fe_q;
  logic              dor_q;

  logic [1:0] rx_s_q;
  logic       rx_prev_q;
  logic [1:0] xk_s_q;
  logic       xk_prev_q;

  logic              txen;
  logic              rxen;
  logic              sync;
  logic              rxs;
  logic              rx_fall;
  logic              xk_rise;
  logic              xk_fall;
  logic              brg_zero;
  logic              tick;
  logic              wr_data;
  logic              wr_ctrl;
  logic              wr_baud;
  logic              rd_req;
  logic              rd_data;

  logic [1:0]        tx_st_q, tx_st_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [BC_W-1:0]   tx_bc_q, tx_bc_d;
  logic [TC_W-1:0]   tx_tc_q, tx_tc_d;
  logic              txd_q, txd_d;
  logic              tx_go;
  logic              tx_adv;
  logic              tx_end;
  logic              tx_load;

  logic [1:0]        rx_st_q, rx_st_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [BC_W-1:0]   rx_bc_q, rx_bc_d;
  logic [TC_W-1:0]   rx_tc_q, rx_tc_d;
  logic              rx_samp;
  logic              rx_done;

  assign txen = ctrl_q[0];
  assign rxen = ctrl_q[1];
  assign sync = ctrl_q[2];

  assign wr_data = bus.wr_en && (bus.addr == A_DATA);
  assign wr_ctrl = bus.wr_en && (bus.addr == A_CTRL);
  assign wr_baud = bus.wr_en && (bus.addr == A_BAUD);
  assign rd_req  = bus.rd_en && !bus.wr_en;
  assign rd_data = rd_req && (bus.addr == A_DATA);

  assign bus.rdata = rdata_q;
  assign txd       = txd_q;

  // Both async inputs get two flops; a third stage gives edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      xk_s_q    <= 2'b00;
      xk_prev_q <= 1'b0;
    end else begin
      rx_s_q    <= {rx_s_q[0], rxd};
      rx_prev_q <= rx_s_q[1];
      xk_s_q    <= {xk_s_q[0], xcki};
      xk_prev_q <= xk_s_q[1];
    end
  end

  assign rxs     = rx_s_q[1];
  assign rx_fall = rx_prev_q & ~rxs;
  assign xk_rise = ~xk_prev_q & xk_s_q[1];
  assign xk_fall = xk_prev_q & ~xk_s_q[1];

  assign brg_zero = (brg_q == '0);
  assign tick     = brg_zero & ~sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brg_q <= '0;
    end else if (wr_baud) begin
      brg_q <= bus.wdata;
    end else if (brg_zero) begin
      brg_q <= baud_q;
    end else begin
      brg_q <= brg_q - 1'b1;
    end
  end

  always_comb begin
    case (bus.addr)
      A_DATA:  rd_mux = rx_buf_q;
      A_STAT:  rd_mux = {{(DATA_W-4){1'b0}},
                         dor_q, fe_q, rxc_q, txe_q};
      A_CTRL:  rd_mux = {{(DATA_W-3){1'b0}}, ctrl_q};
      A_BAUD:  rd_mux = baud_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      baud_q   <= '0;
      rdata_q  <= '0;
      tx_buf_q <= '0;
      txe_q    <= 1'b1;
    end else begin
      if (wr_ctrl) ctrl_q <= bus.wdata[2:0];
      if (wr_baud) baud_q <= bus.wdata;
      if (rd_req)  rdata_q <= rd_mux;
      if (wr_data && txe_q) begin
        tx_buf_q <= bus.wdata;
        txe_q    <= 1'b0;
      end else if (tx_load) begin
        txe_q    <= 1'b1;
      end
    end
  end

  // In sync mode a frame may only begin on a falling xcki edge so
  // that the start bit spans one full xcki period.
  always_comb begin
    tx_st_d = tx_st_q;
    tx_sh_d = tx_sh_q;
    tx_bc_d = tx_bc_q;
    tx_tc_d = tx_tc_q;
    tx_load = 1'b0;
    tx_go   = txen & ~txe_q & (sync ? xk_fall : 1'b1);
    tx_adv  = sync ? xk_fall : tick;
    tx_end  = tx_adv & (sync | (tx_tc_q == TC_LAST));
    if (tx_adv) tx_tc_d = tx_tc_q + 1'b1;
    unique case (tx_st_q)
      S_IDLE: begin
        tx_tc_d = '0;
        if (tx_go) begin
          tx_st_d = S_START;
          tx_sh_d = tx_buf_q;
          tx_load = 1'b1;
        end
      end
      S_START: begin
        if (tx_end) begin
          tx_st_d = S_DATA;
          tx_bc_d = '0;
        end
      end
      S_DATA: begin
        if (tx_end) begin
          tx_sh_d = tx_sh_q >> 1;
          tx_bc_d = tx_bc_q + 1'b1;
          if (tx_bc_q == BC_LAST) tx_st_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_end) begin
          tx_st_d = S_IDLE;
          if (tx_go) begin
            tx_st_d = S_START;
            tx_sh_d = tx_buf_q;
            tx_tc_d = '0;
            tx_load = 1'b1;
          end
        end
      end
    endcase
    unique case (tx_st_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_sh_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q <= S_IDLE;
      tx_sh_q <= '0;
      tx_bc_q <= '0;
      tx_tc_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d;
      tx_sh_q <= tx_sh_d;
      tx_bc_q <= tx_bc_d;
      tx_tc_q <= tx_tc_d;
      txd_q   <= txd_d;
    end
  end

  assign rx_samp = sync ? xk_rise
                        : (tick & (rx_tc_q == TC_LAST));

  // Sync mode samples the start bit from IDLE and goes straight to DATA.
  always_comb begin
    rx_st_d = rx_st_q;
    rx_sh_d = rx_sh_q;
    rx_bc_d = rx_bc_q;
    rx_tc_d = rx_tc_q;
    rx_done = 1'b0;
    if (tick) rx_tc_d = rx_tc_q + 1'b1;
    unique case (rx_st_q)
      S_IDLE: begin
        rx_tc_d = '0;
        rx_bc_d = '0;
        if (rxen && sync && xk_rise && !rxs) begin
          rx_st_d = S_DATA;
        end else if (rxen && !sync && rx_fall) begin
          rx_st_d = S_START;
        end
      end
      S_START: begin
        if (tick && (rx_tc_q == TC_MID)) begin
          rx_tc_d = '0;
          rx_st_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_samp) begin
          rx_sh_d = {rxs, rx_sh_q[DATA_W-1:1]};
          rx_bc_d = rx_bc_q + 1'b1;
          if (rx_bc_q == BC_LAST) rx_st_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_samp) begin
          rx_st_d = S_IDLE;
          rx_done = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q <= S_IDLE;
      rx_sh_q <= '0;
      rx_bc_q <= '0;
      rx_tc_q <= '0;
    end else begin
      rx_st_q <= rx_st_d;
      rx_sh_q <= rx_sh_d;
      rx_bc_q <= rx_bc_d;
      rx_tc_q <= rx_tc_d;
    end
  end

  // A completed frame outranks a DATA read landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_buf_q <= '0;
      rxc_q    <= 1'b0;
      fe_q     <= 1'b0;
      dor_q    <= 1'b0;
    end else begin
      if (rd_data) begin
        rxc_q <= 1'b0;
        fe_q  <= 1'b0;
        dor_q <= 1'b0;
      end
      if (rx_done) begin
        rx_buf_q <= rx_sh_q;
        rxc_q    <= 1'b1;
        if (!rxs) fe_q <= 1'b1;
        if (rxc_q && !rd_data) dor_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usart_core.sv
// Directed-plus-random bench for usart_core against a frame-level model.
// Expected serial bits and status flags come from byte arithmetic.
module tb_usart_core;

  localparam int CLKP = 10;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic xcki    = 1'b0;
  logic xck_en  = 1'b0;
  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;
  logic rxd_w;
  logic txd;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic       m_rxc = 1'b0;
  logic       m_fe  = 1'b0;
  logic       m_dor = 1'b0;
  logic [7:0] m_buf = 8'h00;

  usart_core_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  usart_core #(
    .DATA_W(8), .ADDR_W(2), .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .xcki (xcki),
    .rxd  (rxd_w),
    .txd  (txd)
  );

  assign rxd_w = loop_en ? txd : rxd_drv;

  always #(CLKP/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      #(30*CLKP);
      xcki = xck_en ? ~xcki : 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rdata;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  function automatic logic [7:0] m_status(input logic txe);
    return {4'h0, m_dor, m_fe, m_rxc, txe};
  endfunction

  task automatic m_frame(input logic [7:0] d, input logic stop);
    if (m_rxc) m_dor = 1'b1;
    m_rxc = 1'b1;
    m_buf = d;
    if (!stop) m_fe = 1'b1;
  endtask

  task automatic m_read_data();
    m_rxc = 1'b0;
    m_fe  = 1'b0;
    m_dor = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input int bclk);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (bclk) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (bclk) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic wait_txd_low(output int t0);
    t0 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        t0 = cyc;
        break;
      end
    end
    if (t0 < 0) t0 = cyc;
    chk("tx start bit", 32'(txd), 32'd0);
  endtask

  // Bit k of a 16-clk/bit frame is sampled mid-bit at t0+8+16k.
  task automatic chk_frame(input logic [7:0] d,
                           input int t0,
                           input string tag);
    logic e;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = 1'((d >> (k - 1)) & 8'h01);
      wait_cyc(t0 + 8 + 16*k);
      chk($sformatf("%s bit%0d", tag, k), 32'(txd), 32'(e));
    end
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] d;
    logic [7:0] d2;
    logic [7:0] d3;
    int t0;

    bus.addr  = '0;
    bus.wdata = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset txd", 32'(txd), 32'd1);
    chk("reset rdata", 32'(bus.rdata), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, s); chk("reset status", 32'(s), 32'h01);
    rd(2'd2, s); chk("reset ctrl", 32'(s), 32'h00);
    rd(2'd3, s); chk("reset baud", 32'(s), 32'h00);

    wr(2'd3, 8'h00);
    wr(2'd2, 8'h01);
    for (int n = 0; n < 3; n++) begin
      d = (n == 0) ? 8'hA5 : 8'($urandom);
      wr(2'd0, d);
      wait_txd_low(t0);
      rd(2'd1, s);
      chk("tx txe at start", 32'(s), 32'(m_status(1'b1)));
      chk_frame(d, t0, $sformatf("tx %02h", d));
      wait_cyc(t0 + 168);
      chk("tx idle after", 32'(txd), 32'd1);
    end
    wr(2'd2, 8'h00);

    wr(2'd3, 8'h02);
    wr(2'd2, 8'h02);
    for (int n = 0; n < 3; n++) begin
      d = (n == 0) ? 8'h3C : 8'($urandom);
      send_frame(d, 1'b1, 48);
      m_frame(d, 1'b1);
      rd(2'd1, s);
      chk("rx status", 32'(s), 32'(m_status(1'b1)));
      rd(2'd0, s);
      chk("rx data", 32'(s), 32'(m_buf));
      m_read_data();
      rd(2'd1, s);
      chk("rx status clr", 32'(s), 32'(m_status(1'b1)));
    end

    send_frame(8'h11, 1'b0, 48);
    m_frame(8'h11, 1'b0);
    rd(2'd1, s);
    chk("fe status", 32'(s), 32'(m_status(1'b1)));
    rd(2'd0, s);
    chk("fe data", 32'(s), 32'(m_buf));
    m_read_data();
    d  = 8'($urandom);
    d2 = 8'($urandom);
    send_frame(d, 1'b1, 48);
    m_frame(d, 1'b1);
    send_frame(d2, 1'b1, 48);
    m_frame(d2, 1'b1);
    rd(2'd1, s);
    chk("dor status", 32'(s), 32'(m_status(1'b1)));
    rd(2'd0, s);
    chk("dor data", 32'(s), 32'(m_buf));
    m_read_data();
    rd(2'd1, s);
    chk("dor status clr", 32'(s), 32'(m_status(1'b1)));

    xck_en  = 1'b1;
    loop_en = 1'b1;
    wr(2'd2, 8'h07);
    repeat (20) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      d = (n == 0) ? 8'h5A : 8'($urandom);
      wr(2'd0, d);
      s = 8'h00;
      for (int i = 0; i < 330; i++) begin
        rd(2'd1, s);
        if (s[1]) break;
      end
      m_frame(d, 1'b1);
      chk("sync rxc", 32'(s[1]), 32'd1);
      rd(2'd0, s);
      chk("sync data", 32'(s), 32'(m_buf));
      m_read_data();
      repeat (130) @(negedge clk);
      rd(2'd1, s);
      chk("sync status", 32'(s), 32'(m_status(1'b1)));
    end
    wr(2'd2, 8'h00);
    xck_en  = 1'b0;
    loop_en = 1'b0;

    wr(2'd3, 8'h7F);
    @(negedge clk);
    bus.addr  = 2'd3;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("baud readback", 32'(bus.rdata), 32'h7F);
    @(negedge clk);
    chk("rdata hold", 32'(bus.rdata), 32'h7F);
    bus.addr  = 2'd2;
    bus.wdata = 8'h01;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("wr+rd hold", 32'(bus.rdata), 32'h7F);
    rd(2'd2, s);
    chk("wr+rd ctrl", 32'(s), 32'h01);

    wr(2'd3, 8'h00);
    d  = 8'($urandom);
    d2 = 8'($urandom);
    d3 = ~d2;
    wr(2'd0, d);
    wait_txd_low(t0);
    wr(2'd0, d2);
    wr(2'd0, d3);
    rd(2'd1, s);
    chk("busy txe", 32'(s), 32'h00);
    chk_frame(d, t0, "b2b first");
    chk_frame(d2, t0 + 160, "b2b second");
    wait_cyc(t0 + 328);
    chk("b2b idle", 32'(txd), 32'd1);
    rd(2'd1, s);
    chk("b2b txe", 32'(s), 32'h01);

    wr(2'd0, 8'($urandom));
    wait_txd_low(t0);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe rst txd", 32'(txd), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post rst txd", 32'(txd), 32'd1);
    rd(2'd1, s); chk("post rst status", 32'(s), 32'h01);
    rd(2'd2, s); chk("post rst ctrl", 32'(s), 32'h00);
    rd(2'd3, s); chk("post rst baud", 32'(s), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
